lcd_timing_gen: RTL and testbench

- Parametrised raster timing generator for the LCD/video output path.
- Produces horizontal and vertical counters over the full line/frame, programmable sync/porch/active regions, sync polarity, data-enable, and active-pixel coordinates.
- Adds line and frame strobes and a pixel-enable (iEN) that freezes the raster.
- Feeds pixel generators (line/shape drawers) and the panel interface.

---
 rtl/lcd_timing_gen.sv | 104 ++++++++++
 tb/tb_lcd_timing_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing generator with sync, data-enable, pixel coordinates and line/frame strobes
// Ports: iCLK pixel clock, iRST sync active-high reset, iEN raster advance enable,
//        x_cnt/y_cnt raster position, o_hs/o_vs syncs, o_de data enable,
//        o_px/o_py active pixel coordinates, o_line_start/o_frame_start/o_frame_end strobes
module lcd_timing_gen #(
   parameter int XW       = 11,
   parameter int YW       = 10,
   parameter int H_SYNC   = 1,
   parameter int H_BACK   = 45,
   parameter int H_ACTIVE = 800,
   parameter int H_FRONT  = 210,
   parameter int V_SYNC   = 1,
   parameter int V_BACK   = 22,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 22,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iEN,
   output logic [XW-1:0] x_cnt,
   output logic [YW-1:0] y_cnt,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_de,
   output logic [XW-1:0] o_px,
   output logic [YW-1:0] o_py,
   output logic          o_line_start,
   output logic          o_frame_start,
   output logic          o_frame_end
);
   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] HS_END = XW'(H_SYNC);
   localparam logic [YW-1:0] VS_END = YW'(V_SYNC);
   localparam logic [XW-1:0] HA0 = XW'(H_SYNC + H_BACK);
   localparam logic [XW-1:0] HA1 = XW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [YW-1:0] VA0 = YW'(V_SYNC + V_BACK);
   localparam logic [YW-1:0] VA1 = YW'(V_SYNC + V_BACK + V_ACTIVE);
   if (longint'(H_TOTAL) > (longint'(1) << XW) || longint'(V_TOTAL) > (longint'(1) << YW)) begin : g_size_err
      $error("lcd_timing_gen: H_TOTAL/V_TOTAL do not fit in XW/YW");
   end
   logic          run_q;
   logic [XW-1:0] x_q, x_d, px_q, px_d;
   logic [YW-1:0] y_q, y_d, py_q, py_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic          ls_q, ls_d, fs_q, fs_d, fe_q, fe_d;
   logic          adv, x_wrap;
   // run_q is clear only on the first cycle after reset, which holds (0,0) and announces it
   always_comb begin
      adv    = iEN & run_q;
      x_wrap = x_q == H_LAST;
      x_d    = adv ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
      y_d    = (adv & x_wrap) ? ((y_q == V_LAST) ? '0 : y_q + 1'b1) : y_q;
      hs_d   = (x_d < HS_END) ? HS_POL : ~HS_POL;
      vs_d   = (y_d < VS_END) ? VS_POL : ~VS_POL;
      de_d   = (x_d >= HA0) && (x_d < HA1) && (y_d >= VA0) && (y_d < VA1);
      px_d   = de_d ? x_d - HA0 : '0;
      py_d   = de_d ? y_d - VA0 : '0;
      ls_d   = ~run_q | (adv & (x_d == '0));
      fs_d   = ~run_q | (adv & (x_d == '0) & (y_d == '0));
      fe_d   = adv & (x_d == H_LAST) & (y_d == V_LAST);
   end
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         run_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         hs_q  <= HS_POL;
         vs_q  <= VS_POL;
         de_q  <= 1'b0;
         px_q  <= '0;
         py_q  <= '0;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
         fe_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         de_q  <= de_d;
         px_q  <= px_d;
         py_q  <= py_d;
         ls_q  <= ls_d;
         fs_q  <= fs_d;
         fe_q  <= fe_d;
      end
   end
   assign x_cnt         = x_q;
   assign y_cnt         = y_q;
   assign o_hs          = hs_q;
   assign o_vs          = vs_q;
   assign o_de          = de_q;
   assign o_px          = px_q;
   assign o_py          = py_q;
   assign o_line_start  = ls_q;
   assign o_frame_start = fs_q;
   assign o_frame_end   = fe_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed self-checking bench for lcd_timing_gen on a 14x7 raster
module tb_lcd_timing_gen;
   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iEN = 1'b1;
   logic [10:0] x_cnt, o_px;
   logic [9:0]  y_cnt, o_py;
   logic        o_hs, o_vs, o_de, o_line_start, o_frame_start, o_frame_end;
   int          vecs = 0;
   int          errs = 0;
   int          de_cnt = 0;
   int          ls_cnt = 0;
   int          fs_cnt = 0;
   int          fe_cnt = 0;
   int          fs_last = 0;
   lcd_timing_gen #(
      .XW(11), .YW(10),
      .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b1)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
      .x_cnt(x_cnt), .y_cnt(y_cnt),
      .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
      .o_px(o_px), .o_py(o_py),
      .o_line_start(o_line_start), .o_frame_start(o_frame_start), .o_frame_end(o_frame_end)
   );
   always #5 iCLK = ~iCLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge iCLK);
         @(negedge iCLK);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_x"}, 32'(x_cnt), 0);
      chk({tag, "_y"}, 32'(y_cnt), 0);
      chk({tag, "_hs"}, 32'(o_hs), 0);
      chk({tag, "_vs"}, 32'(o_vs), 1);
      chk({tag, "_de"}, 32'(o_de), 0);
      chk({tag, "_px"}, 32'(o_px), 0);
      chk({tag, "_py"}, 32'(o_py), 0);
      chk({tag, "_ls"}, 32'(o_line_start), 0);
      chk({tag, "_fs"}, 32'(o_frame_start), 0);
      chk({tag, "_fe"}, 32'(o_frame_end), 0);
   endtask
   initial begin
      step(2);
      chk_reset("rst");
      iRST = 1'b0;
      step(1);
      chk("c0_x", 32'(x_cnt), 0);
      chk("c0_y", 32'(y_cnt), 0);
      chk("c0_fs", 32'(o_frame_start), 1);
      chk("c0_ls", 32'(o_line_start), 1);
      chk("c0_hs", 32'(o_hs), 0);
      chk("c0_vs", 32'(o_vs), 1);
      chk("c0_de", 32'(o_de), 0);
      ls_cnt = 1;
      for (int c = 1; c <= 294; c++) begin
         step(1);
         if (c < 98) begin
            de_cnt += int'(o_de);
            ls_cnt += int'(o_line_start);
         end
         fs_cnt += int'(o_frame_start);
         fe_cnt += int'(o_frame_end);
         if (o_frame_start) fs_last = c;
         if (c == 1) chk("c1_hs", 32'(o_hs), 0);
         if (c == 2) chk("c2_hs", 32'(o_hs), 1);
         if (c == 13) chk("c13_vs", 32'(o_vs), 1);
         if (c == 14) begin
            chk("c14_ls", 32'(o_line_start), 1);
            chk("c14_x", 32'(x_cnt), 0);
            chk("c14_y", 32'(y_cnt), 1);
            chk("c14_vs", 32'(o_vs), 0);
         end
         if (c == 31) chk("c31_de", 32'(o_de), 0);
         if (c == 32) begin
            chk("c32_de", 32'(o_de), 1);
            chk("c32_x", 32'(x_cnt), 4);
            chk("c32_y", 32'(y_cnt), 2);
            chk("c32_px", 32'(o_px), 0);
            chk("c32_py", 32'(o_py), 0);
         end
         if (c == 81) begin
            chk("c81_de", 32'(o_de), 1);
            chk("c81_px", 32'(o_px), 7);
            chk("c81_py", 32'(o_py), 3);
         end
         if (c == 82) begin
            chk("c82_de", 32'(o_de), 0);
            chk("c82_x", 32'(x_cnt), 12);
            chk("c82_px", 32'(o_px), 0);
         end
         if (c == 96) chk("c96_fe", 32'(o_frame_end), 0);
         if (c == 97) begin
            chk("c97_fe", 32'(o_frame_end), 1);
            chk("c97_x", 32'(x_cnt), 13);
            chk("c97_y", 32'(y_cnt), 6);
            chk("c97_vs", 32'(o_vs), 0);
         end
         if (c == 98) begin
            chk("c98_x", 32'(x_cnt), 0);
            chk("c98_y", 32'(y_cnt), 0);
            chk("c98_fs", 32'(o_frame_start), 1);
            chk("c98_ls", 32'(o_line_start), 1);
            chk("c98_fe", 32'(o_frame_end), 0);
            chk("c98_vs", 32'(o_vs), 1);
         end
      end
      chk("de_per_frame", 32'(de_cnt), 32);
      chk("ls_per_frame", 32'(ls_cnt), 7);
      chk("fs_3frames", 32'(fs_cnt), 3);
      chk("fe_3frames", 32'(fe_cnt), 3);
      chk("fs_last", 32'(fs_last), 294);
      step(42);
      chk("hold_entry_x", 32'(x_cnt), 0);
      chk("hold_entry_y", 32'(y_cnt), 3);
      chk("hold_entry_ls", 32'(o_line_start), 1);
      iEN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("hold_x", 32'(x_cnt), 0);
         chk("hold_y", 32'(y_cnt), 3);
         chk("hold_ls", 32'(o_line_start), 0);
         chk("hold_hs", 32'(o_hs), 0);
         chk("hold_de", 32'(o_de), 0);
         chk("hold_px", 32'(o_px), 0);
      end
      iEN = 1'b1;
      step(1);
      chk("resume_x", 32'(x_cnt), 1);
      chk("resume_y", 32'(y_cnt), 3);
      chk("resume_ls", 32'(o_line_start), 0);
      step(19);
      chk("mid_x", 32'(x_cnt), 6);
      chk("mid_y", 32'(y_cnt), 4);
      chk("mid_de", 32'(o_de), 1);
      chk("mid_px", 32'(o_px), 2);
      chk("mid_py", 32'(o_py), 2);
      iRST = 1'b1;
      step(1);
      chk_reset("midrst");
      iRST = 1'b0;
      step(1);
      chk("post_rst_x", 32'(x_cnt), 0);
      chk("post_rst_y", 32'(y_cnt), 0);
      chk("post_rst_fs", 32'(o_frame_start), 1);
      chk("post_rst_ls", 32'(o_line_start), 1);
      step(1);
      chk("post_rst_adv_x", 32'(x_cnt), 1);
      chk("post_rst_adv_fs", 32'(o_frame_start), 0);
      step(96);
      chk("end_x", 32'(x_cnt), 13);
      chk("end_y", 32'(y_cnt), 6);
      chk("end_fe", 32'(o_frame_end), 1);
      iEN = 1'b0;
      step(1);
      chk("end_hold_x", 32'(x_cnt), 13);
      chk("end_hold_y", 32'(y_cnt), 6);
      chk("end_hold_fe", 32'(o_frame_end), 0);
      iRST = 1'b1;
      iEN = 1'b1;
      step(1);
      chk_reset("rst_en");
      iRST = 1'b0;
      iEN = 1'b0;
      step(1);
      chk("rel_noen_x", 32'(x_cnt), 0);
      chk("rel_noen_fs", 32'(o_frame_start), 1);
      chk("rel_noen_ls", 32'(o_line_start), 1);
      step(1);
      chk("rel_hold_x", 32'(x_cnt), 0);
      chk("rel_hold_fs", 32'(o_frame_start), 0);
      chk("rel_hold_ls", 32'(o_line_start), 0);
      iEN = 1'b1;
      step(1);
      chk("rel_adv_x", 32'(x_cnt), 1);
      chk("rel_adv_y", 32'(y_cnt), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
